// File: rtl/axi_lite_traffic_gen.sv
// AXI single-beat write/readback traffic generator with built-in checker.
// Transaction i writes DATA_SEED+i to BASE_ADDR+4*i, reads it back and counts mismatches.
module axi_lite_traffic_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ID_W      = 4,
  parameter int unsigned       NUM_TXN   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [DATA_W-1:0] DATA_SEED = 32'hABCD_1234,
  parameter int unsigned       TIMEOUT   = 4096
) (
  input  logic                m_clk_wr,
  input  logic                m_rst_wr_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [15:0]         err_count,
  output logic [15:0]         txn_count,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [ID_W-1:0]     awid,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [ID_W-1:0]     arid,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic [ID_W-1:0]     rid,
  input  logic                rlast
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned PH_W     = $clog2(TIMEOUT + 1);
  localparam logic [2:0]  AXI_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_B, S_RD_AR, S_RD_R, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [15:0]         i_q, i_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         err_count_q, err_count_d, txn_count_q, txn_count_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [ID_W-1:0]     awid_q, awid_d, arid_q, arid_d;
  logic [7:0]          awlen_q, awlen_d, arlen_q, arlen_d;
  logic [2:0]          awsize_q, awsize_d, arsize_q, arsize_d;
  logic [1:0]          awburst_q, awburst_d, arburst_q, arburst_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                wlast_q, wlast_d;

  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_data;
  logic [ID_W-1:0]     cur_id;
  logic                aw_hs, w_hs, err_inc;

  assign cur_addr = BASE_ADDR + (ADDR_W'(i_q) << 2);
  assign cur_data = DATA_SEED + DATA_W'(i_q);
  assign cur_id   = i_q[ID_W-1:0];
  assign aw_hs    = awvalid_q && awready;
  assign w_hs     = wvalid_q && wready;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d     = state_q;
    i_d         = i_q;
    phase_d     = phase_q + 1'b1;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_count_d = err_count_q;
    txn_count_d = txn_count_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    awid_d      = awid_q;
    awlen_d     = awlen_q;
    awsize_d    = awsize_q;
    awburst_d   = awburst_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    wlast_d     = wlast_q;
    araddr_d    = araddr_q;
    arid_d      = arid_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    arburst_d   = arburst_q;
    err_inc     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d         = '0;
          err_count_d = '0;
          txn_count_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        // The first WR cycle only loads the payload, giving the idle gap between transactions.
        if (!awvalid_q && !aw_done_q) begin
          awvalid_d = 1'b1;
          awaddr_d  = cur_addr;
          awid_d    = cur_id;
          awlen_d   = '0;
          awsize_d  = AXI_SIZE;
          awburst_d = 2'b01;
        end
        if (!wvalid_q && !w_done_q) begin
          wvalid_d = 1'b1;
          wdata_d  = cur_data;
          wstrb_d  = '1;
          wlast_d  = 1'b1;
        end
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = S_WR_B;
        end
      end
      S_WR_B: begin
        if (bvalid && bready_q) begin
          err_inc   = (bresp != 2'b00) || (bid != awid_q);
          bready_d  = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = cur_addr;
          arid_d    = cur_id;
          arlen_d   = '0;
          arsize_d  = AXI_SIZE;
          arburst_d = 2'b01;
          state_d   = S_RD_AR;
        end
      end
      S_RD_AR: begin
        if (arvalid_q && arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end
      S_RD_R: begin
        if (rvalid && rready_q) begin
          err_inc     = (rdata != wdata_q) || (rresp != 2'b00) || (rid != arid_q) || !rlast;
          rready_d    = 1'b0;
          txn_count_d = txn_count_q + 16'd1;
          if (i_q == 16'(NUM_TXN - 1)) begin
            state_d = S_DONE;
          end else begin
            i_d     = i_q + 16'd1;
            state_d = S_WR;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_count_q == '0) && !timeout_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bring-up abort: valids are withdrawn without a handshake when a phase stalls.
    if ((state_q inside {S_WR, S_WR_B, S_RD_AR, S_RD_R}) && (state_d == state_q) &&
        (phase_q == PH_W'(TIMEOUT - 1))) begin
      timeout_d = 1'b1;
      err_inc   = 1'b1;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
      state_d   = S_DONE;
    end

    if (err_inc && (err_count_q != '1)) err_count_d = err_count_q + 16'd1;
    if (state_d != state_q) phase_d = '0;
  end

  always_ff @(posedge m_clk_wr or negedge m_rst_wr_n) begin
    if (!m_rst_wr_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      phase_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      txn_count_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      awid_q      <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wlast_q     <= 1'b0;
      araddr_q    <= '0;
      arid_q      <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
    end else begin
      // NOTE: non-blocking updates make every flop see the same pre-edge values.
      state_q     <= state_d;
      i_q         <= i_d;
      phase_q     <= phase_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      txn_count_q <= txn_count_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      awid_q      <= awid_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      awburst_q   <= awburst_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      wlast_q     <= wlast_d;
      araddr_q    <= araddr_d;
      arid_q      <= arid_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign err_count = err_count_q;
  assign txn_count = txn_count_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign awid      = awid_q;
  assign awlen     = awlen_q;
  assign awsize    = awsize_q;
  assign awburst   = awburst_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign wlast     = wlast_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arid      = arid_q;
  assign arlen     = arlen_q;
  assign arsize    = arsize_q;
  assign arburst   = arburst_q;
  assign rready    = rready_q;

endmodule
